div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divide/remainder unit sitting between the register-file read ports and its write port. It takes the two source operands read from the register file, computes DIV/DIVU/REM/REMU over multiple cycles with a restoring shift-subtract algorithm, and returns the result with a write-enable and destination index. Those three outputs drive the register file's write interface directly. The core stalls on `busy`.

## Interface
- `XLEN`, 32: operand and result width. Iteration count equals XLEN.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1Data`  in  XLEN  dividend (register-file rdData1).
- `rs2Data`  in  XLEN  divisor (register-file rdData2).
- `rdIn`  in  5  destination register index.
- `busy`  out  1  high in CALC, FIX and DONE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  XLEN  quotient or remainder. Held until the next accepted start.
- `wrtReg`  out  5  latched destination index, to the register-file wrtReg.
- `wrtEn`  out  1  equals `done && (wrtReg != 0)`, to the register-file wrtEn.

## Operation
- **States:** IDLE, CALC, FIX, DONE. The state, the 6-bit iteration counter and all outputs are registers.
- **Operand capture (IDLE with `start`=1):**
  - Latch `op` and `rdIn`.
  - Signed ops (DIV, REM): store |rs1| and |rs2|, plus `negQ = sign1 ^ sign2` and `negR = sign1`.
  - Unsigned ops: store the raw operands, with both negate flags 0.
- **Special cases, resolved at capture and going straight to DONE:**
  - Divisor 0: quotient = all ones; remainder = rs1Data unmodified (both signed and unsigned).
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- **Otherwise, transition to CALC with counter 0.**
- **CALC:** one restoring step per cycle.
  - `{rem,quo}` shifts left 1.
  - If `rem >= divisor`, then `rem -= divisor` and `quo[0] = 1`.
  - The remainder register is XLEN+1 bits so the compare never overflows.
  - After XLEN steps, go to FIX.
- **FIX:**
  - `result` = `negQ ? -quo : quo` for DIV/DIVU.
  - `result` = `negR ? -rem : rem` for REM/REMU.
  - Arithmetic is two's complement, truncated to XLEN.
  - Go to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then return to IDLE.
- **`start` outside IDLE:** ignored; operands are not re-sampled.
- **Reset, at any time including mid-CALC:**
  - State → IDLE, counter → 0, internal operand registers → 0.
  - `busy`, `done`, `wrtEn` → 0; `result` → 0; `wrtReg` → 0.
  - No write is issued for the aborted operation.

## Timing
- Normal path:
  - `start` is sampled at edge N.
  - CALC occupies edges N+1 … N+XLEN.
  - FIX registers `result` at edge N+XLEN+1.
  - `done`/`wrtEn` are high during the cycle following edge N+XLEN+1 (N+33 for XLEN=32). `result` is valid in that same cycle.
- Special-case path: `done` is high during the cycle following edge N (latency 1).
- `busy` rises in the cycle after the accepting edge and falls together with the end of the `done` cycle.
- A new `start` can be accepted in the first IDLE cycle after DONE, so back-to-back throughput is XLEN+3 cycles.
- The register file writes on the edge that ends the `done` cycle. The upstream core holds `rs1Data`/`rs2Data` only through the accepting edge.

## Test plan
- DIVU 100 / 7, rd=5 → `done` 33 cycles after start. `result` = 14, `wrtReg` = 5, `wrtEn` = 1 for one cycle. REMU with the same operands → 2.
- DIV -7 / 2 → 0xFFFFFFFD (-3). REM -7 / 2 → 0xFFFFFFFF (-1). REM 7 / -2 → 1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 with latency 1. REM with the same operands → 0.
- DIVU 5 / 0 → 0xFFFFFFFF. REM 0xFFFFFFF9 / 0 → 0xFFFFFFF9. Both with latency 1.
- rd=0, DIVU 9/3 → `done` = 1 with `wrtEn` = 0. Then a `start` pulse mid-CALC → ignored, and the first result is still 3.
- Assert `rst` at CALC cycle 10 → next cycle all outputs are 0 and state is IDLE; no `wrtEn` pulse. A fresh DIVU 10/3 afterwards → 3.

Source files
------------

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV/DIVU/REM/REMU), one restoring
// shift-subtract step per cycle, driving the register-file write port directly.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic [4:0]      rdIn,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wrtReg,
  output logic            wrtEn,
  output logic [1:0]      dbgState
);

  // Handshake: start is a one-cycle request honoured only while IDLE (busy=0);
  // done pulses for exactly one cycle with result/wrtReg/wrtEn valid alongside.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, stateN;
  logic [5:0]      cnt, cntN;
  logic            remOp, remOpN;
  logic            negQ, negQN, negR, negRN;
  logic [XLEN-1:0] divisor, divisorN;
  logic [XLEN-1:0] quo, quoN;
  logic [XLEN:0]   rem, remN;
  logic [XLEN-1:0] resultN;
  logic [4:0]      wrtRegN;
  logic            busyN, doneN, wrtEnN;

  logic            isSigned, sign1, sign2, divByZero, overflow, geq;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN+1:0] shiftedExt;
  logic [XLEN:0]   diff;

  assign isSigned  = ~op[0];
  assign sign1     = isSigned & rs1Data[XLEN-1];
  assign sign2     = isSigned & rs2Data[XLEN-1];
  assign abs1      = sign1 ? -rs1Data : rs1Data;
  assign abs2      = sign2 ? -rs2Data : rs2Data;
  assign divByZero = (rs2Data == '0);
  assign overflow  = isSigned && (rs1Data == MIN_NEG) && (rs2Data == '1);

  // rem never exceeds the divisor after a step, so the top bit stays clear;
  // the extra width keeps the shifted compare from wrapping.
  assign shiftedExt = {rem, quo[XLEN-1]};
  assign geq        = (shiftedExt >= {2'b00, divisor});
  assign diff       = shiftedExt[XLEN:0] - {1'b0, divisor};

  assign dbgState = state;

  always_comb begin
    stateN   = state;
    cntN     = cnt;
    remOpN   = remOp;
    negQN    = negQ;
    negRN    = negR;
    divisorN = divisor;
    quoN     = quo;
    remN     = rem;
    resultN  = result;
    wrtRegN  = wrtReg;
    busyN    = busy;
    doneN    = done;
    wrtEnN   = wrtEn;
    case (state)
      IDLE: begin
        if (start) begin
          remOpN  = op[1];
          wrtRegN = rdIn;
          busyN   = 1'b1;
          if (divByZero || overflow) begin
            if (divByZero) resultN = op[1] ? rs1Data : '1;
            else           resultN = op[1] ? '0 : MIN_NEG;
            doneN  = 1'b1;
            wrtEnN = (rdIn != 5'd0);
            stateN = DONE;
          end else begin
            divisorN = abs2;
            quoN     = abs1;
            remN     = '0;
            negQN    = sign1 ^ sign2;
            negRN    = sign1;
            cntN     = 6'd0;
            stateN   = CALC;
          end
        end
      end
      CALC: begin
        cntN = cnt + 6'd1;
        if (geq) begin
          remN = diff;
          quoN = {quo[XLEN-2:0], 1'b1};
        end else begin
          remN = shiftedExt[XLEN:0];
          quoN = {quo[XLEN-2:0], 1'b0};
        end
        if (cnt == 6'(XLEN-1)) begin
          cntN   = 6'd0;
          stateN = FIX;
        end
      end
      FIX: begin
        if (remOp) resultN = negR ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        else       resultN = negQ ? -quo : quo;
        doneN  = 1'b1;
        wrtEnN = (wrtReg != 5'd0);
        stateN = DONE;
      end
      DONE: begin
        doneN  = 1'b0;
        wrtEnN = 1'b0;
        busyN  = 1'b0;
        stateN = IDLE;
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      remOp   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      result  <= '0;
      wrtReg  <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrtEn   <= 1'b0;
    end else begin
      state   <= stateN;
      cnt     <= cntN;
      remOp   <= remOpN;
      negQ    <= negQN;
      negR    <= negRN;
      divisor <= divisorN;
      quo     <= quoN;
      rem     <= remN;
      result  <= resultN;
      wrtReg  <= wrtRegN;
      busy    <= busyN;
      done    <= doneN;
      wrtEn   <= wrtEnN;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model with an
// expected-transaction queue, per-cycle compare process, and directed cases.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1Data, rs2Data;
  logic [4:0]  rdIn;
  logic        busy, done, wrtEn;
  logic [31:0] result;
  logic [4:0]  wrtReg;
  logic [1:0]  dbgState;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .rdIn(rdIn),
    .busy(busy), .done(done), .result(result), .wrtReg(wrtReg),
    .wrtEn(wrtEn), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model
  function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'd0:    return 32'($signed(a) / $signed(b));
      2'd1:    return a / b;
      2'd2:    return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  function automatic bit isSpecial(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          dcyc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] lastResult;
  logic [4:0]  lastWrtReg;
  logic        lastWrtEn;
  int          lastLat;
  logic        due, busyE;

  // compare process (scoreboard)
  always @(negedge clk) begin
    if (!rst) begin
      due   = (exp_q.size() > 0) && (exp_q[0].dcyc == cyc);
      busyE = (exp_q.size() > 0) && (cyc >= exp_q[0].acc);
      chk("busy", {31'd0, busy}, {31'd0, busyE});
      chk("done", {31'd0, done}, {31'd0, due});
      if (due) begin
        chk("result", result, exp_q[0].res);
        chk("wrtReg", {27'd0, wrtReg}, {27'd0, exp_q[0].rd});
        chk("wrtEn", {31'd0, wrtEn}, {31'd0, exp_q[0].rd != 5'd0});
        lastResult = result;
        lastWrtReg = wrtReg;
        lastWrtEn  = wrtEn;
        lastLat    = cyc - exp_q[0].acc;
        void'(exp_q.pop_front());
      end else begin
        chk("wrtEn_idle", {31'd0, wrtEn}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; rs1Data = a; rs2Data = b; rdIn = rd;
    @(posedge clk);
    #1;
    e.res  = refResult(o, a, b);
    e.rd   = rd;
    e.acc  = cyc;
    e.dcyc = cyc + (isSpecial(o, a, b) ? 0 : 33);
    exp_q.push_back(e);
    start   = 1'b0;
    rs1Data = $urandom;
    rs2Data = $urandom;
    rdIn    = 5'($urandom);
    op      = 2'($urandom);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("wait_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd);
    issue(o, a, b, rd);
    waitIdle();
  endtask

  task automatic checkZeroOutputs(input string tag);
    chk({tag, "_busy"},   {31'd0, busy},   32'd0);
    chk({tag, "_done"},   {31'd0, done},   32'd0);
    chk({tag, "_wrtEn"},  {31'd0, wrtEn},  32'd0);
    chk({tag, "_result"}, result,          32'd0);
    chk({tag, "_wrtReg"}, {27'd0, wrtReg}, 32'd0);
    chk({tag, "_state"},  {30'd0, dbgState}, 32'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; rs1Data = '0; rs2Data = '0; rdIn = '0;
    repeat (3) @(posedge clk);
    #1;
    checkZeroOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // hand-computed pins on the model itself
    chk("model_div_m7_2", refResult(2'd0, -32'd7, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem_7_m2", refResult(2'd2, 32'd7, -32'd2), 32'd1);
    chk("model_remu_div0", refResult(2'd3, 32'd5, 32'd0), 32'd5);

    run(2'd1, 32'd100, 32'd7, 5'd5);
    chk("divu_100_7", lastResult, 32'd14);
    chk("divu_lat", 32'(lastLat), 32'd33);
    chk("divu_wrtReg", {27'd0, lastWrtReg}, 32'd5);
    chk("divu_wrtEn", {31'd0, lastWrtEn}, 32'd1);
    run(2'd3, 32'd100, 32'd7, 5'd5);
    chk("remu_100_7", lastResult, 32'd2);

    run(2'd0, -32'd7, 32'd2, 5'd1);
    chk("div_m7_2", lastResult, 32'hFFFF_FFFD);
    run(2'd2, -32'd7, 32'd2, 5'd2);
    chk("rem_m7_2", lastResult, 32'hFFFF_FFFF);
    run(2'd2, 32'd7, -32'd2, 5'd3);
    chk("rem_7_m2", lastResult, 32'd1);

    run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    chk("div_ovf", lastResult, 32'h8000_0000);
    chk("div_ovf_lat", 32'(lastLat), 32'd0);
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    chk("rem_ovf", lastResult, 32'd0);

    run(2'd1, 32'd5, 32'd0, 5'd6);
    chk("divu_div0", lastResult, 32'hFFFF_FFFF);
    chk("divu_div0_lat", 32'(lastLat), 32'd0);
    run(2'd2, 32'hFFFF_FFF9, 32'd0, 5'd7);
    chk("rem_div0", lastResult, 32'hFFFF_FFF9);
    chk("rem_div0_lat", 32'(lastLat), 32'd0);

    // rd=0 with a stray start mid-CALC
    issue(2'd1, 32'd9, 32'd3, 5'd0);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd1; rs1Data = 32'd50; rs2Data = 32'd5; rdIn = 5'd9;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    chk("rd0_result", lastResult, 32'd3);
    chk("rd0_wrtEn", {31'd0, lastWrtEn}, 32'd0);

    // reset during CALC
    issue(2'd1, 32'hDEAD_BEEF, 32'd3, 5'd8);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkZeroOutputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    run(2'd1, 32'd10, 32'd3, 5'd10);
    chk("post_reset_divu", lastResult, 32'd3);

    // randomized back-to-back traffic
    for (int i = 0; i < 150; i++) begin
      run(2'($urandom), pickOperand(), pickOperand(), 5'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
